// File: rtl/search_tab_ctrl.sv
// Round-robin arbiter and sequential byte scanner over a shared table RAM. o_gnt arrives in the request cycle.
// o_done follows the last returning read by one cycle. No new grant is made while a scan is in progress.
module search_tab_ctrl #(
    parameter int N_REQ     = 4,
    parameter int N_TAB     = 15,
    parameter int TAB_BYTES = 1399,
    parameter int ADDR_W    = 15,
    parameter int IDX_W     = 11,
    parameter int RD_LAT    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*4-1:0]   i_tab,
    input  logic [N_REQ*8-1:0]   i_key,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_done,
    output logic                 o_hit,
    output logic                 o_err,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_busy,
    output logic                 o_ram_rd,
    output logic [ADDR_W-1:0]    o_ram_addr,
    input  logic [7:0]           i_ram_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, RESP} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    owner_q, owner_d;
    logic [7:0]          key_q, key_d;
    logic                err_q, err_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    off_q, off_d;
    logic [IDX_W-1:0]    ret_q, ret_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    cand;
    logic                gnt_any;
    logic                arb_fire;
    logic [3:0]          sel_tab;
    logic [7:0]          sel_key;
    logic                tab_ok;
    logic                rd_en;
    logic                data_vld;
    logic                match;
    logic                last_issue;

    // Search starts one past the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_any && i_req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_tab    = i_tab[{gnt_idx, 2'b00} +: 4];
    assign sel_key    = i_key[{gnt_idx, 3'b000} +: 8];
    assign tab_ok     = (sel_tab != 4'd0) && (int'(sel_tab) <= N_TAB);
    assign arb_fire   = (state_q == IDLE) && gnt_any && !i_rst;
    assign rd_en      = (state_q == SCAN);
    assign data_vld   = pipe_q[RD_LAT-1];
    assign match      = data_vld && (i_ram_data == key_q) &&
                        ((state_q == SCAN) || (state_q == FLUSH));
    assign last_issue = rd_en && (off_q == IDX_W'(TAB_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_fire) begin
                    state_d = tab_ok ? SCAN : RESP;
                end
            end
            SCAN: begin
                if (match || last_issue) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        key_d   = key_q;
        err_d   = err_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        off_d   = off_q;
        ret_d   = ret_q;
        addr_d  = addr_q;
        pipe_d  = (pipe_q << 1) | RD_LAT'(rd_en);
        cnt_d   = cnt_q;

        if (arb_fire) begin
            ptr_d   = gnt_idx;
            owner_d = N_REQ'(1) << gnt_idx;
            key_d   = sel_key;
            err_d   = !tab_ok;
            hit_d   = 1'b0;
            idx_d   = '0;
            off_d   = '0;
            ret_d   = '0;
            addr_d  = tab_ok ? ADDR_W'((int'(sel_tab) - 1) * TAB_BYTES) : '0;
        end

        if (rd_en) begin
            addr_d = addr_q + 1'b1;
            off_d  = off_q + 1'b1;
        end

        // Returned bytes arrive in issue order, so a running count gives their offset.
        if (data_vld) begin
            ret_d = ret_q + 1'b1;
        end
        if (match && !hit_q) begin
            hit_d = 1'b1;
            idx_d = ret_q;
        end

        if (rd_en && !data_vld) begin
            if (cnt_q < CNT_W'(RD_LAT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!rd_en && data_vld) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            ret_q   <= '0;
            addr_q  <= '0;
            pipe_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            key_q   <= key_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            ret_q   <= ret_d;
            addr_q  <= addr_d;
            pipe_q  <= pipe_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        o_gnt      = arb_fire ? (N_REQ'(1) << gnt_idx) : '0;
        o_busy     = (state_q != IDLE);
        o_ram_rd   = rd_en;
        o_ram_addr = rd_en ? addr_q : '0;
        o_done     = '0;
        o_hit      = 1'b0;
        o_err      = 1'b0;
        o_idx      = '0;
        if (state_q == RESP) begin
            o_done = owner_q;
            o_hit  = hit_q;
            o_err  = err_q;
            o_idx  = hit_q ? idx_q : '0;
        end
    end

endmodule
